pipelined_csel_adder: RTL and testbench



---
 rtl/csel_pkg.sv | 40 ++++
 rtl/csel_slice.sv | 42 ++++
 rtl/pipelined_csel_adder.sv | 171 +++++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: stage count,
// a one-bit full adder, and the signed saturation bounds.
package csel_pkg;

  // Upper bound on operand width that the saturation helpers can describe.
  localparam int CSEL_MAX_WIDTH = 256;

  // Number of pipeline stages (one carry-select slice per stage).
  function automatic int csel_num_stages(input int width, input int block);
    return width / block;
  endfunction

  // One-bit full adder, returned as {carry_out, sum}.
  function automatic logic [1:0] csel_full_add(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    return {co, s};
  endfunction

  // Largest positive two's-complement value of the given width (0x7F..F).
  function automatic logic [CSEL_MAX_WIDTH-1:0] csel_sat_max(input int width);
    logic [CSEL_MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value of the given width (0x80..0).
  function automatic logic [CSEL_MAX_WIDTH-1:0] csel_sat_min(input int width);
    logic [CSEL_MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/csel_slice.sv
// One carry-select slice: two BLOCK-bit ripple-carry chains evaluated in
// parallel, one assuming carry-in 0 and one assuming carry-in 1. The
// enclosing pipeline picks the right pair once the real carry is known.
module csel_slice
  import csel_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic             cout0,
  output logic [BLOCK-1:0] sum1,
  output logic             cout1
);

  // Ripple carries of the two speculative chains; bit 0 is the assumed carry-in.
  logic [BLOCK:0] c0;
  logic [BLOCK:0] c1;

  assign c0[0] = 1'b0;
  assign c1[0] = 1'b1;

  genvar gi;
  // Full-adder cells, one per bit, for both speculative chains.
  for (gi = 0; gi < BLOCK; gi++) begin : gen_fa
    logic [1:0] fa0;
    logic [1:0] fa1;

    assign fa0 = csel_full_add(a[gi], b[gi], c0[gi]);
    assign fa1 = csel_full_add(a[gi], b[gi], c1[gi]);

    assign sum0[gi]  = fa0[0];
    assign c0[gi+1]  = fa0[1];
    assign sum1[gi]  = fa1[0];
    assign c1[gi+1]  = fa1[1];
  end

  assign cout0 = c0[BLOCK];
  assign cout1 = c1[BLOCK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor. WIDTH-bit operands are split into
// BLOCK-bit slices; stage k resolves slice k using the registered carry from
// stage k-1, so latency is WIDTH/BLOCK cycles and throughput is one beat per
// cycle. A single global advance signal stalls every stage together, which
// gives full backpressure without collapsing bubbles.
//
// Optional build macro: CSEL_ADD_SAT_EN -- when defined, the final stage
// clamps signed overflow to 0x7F..F / 0x80..0 (out_ovf still reported,
// out_cout unchanged). When undefined the raw wrapped sum is output.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int S = csel_num_stages(WIDTH, BLOCK);

  // Reject configurations where the slices do not tile the operand exactly.
  if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : gen_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // Whole pipeline moves when the output slot is empty or being drained.
  logic adv;
  logic accept;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;
  assign accept   = in_valid & in_ready;

  genvar gi;
  for (gi = 0; gi < S; gi++) begin : gen_stage
    // Inputs to this stage: operands still to be resolved, partial sum,
    // carry into this slice, and the beat's valid bit.
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic             src_cin;
    logic             src_valid;

    // Speculative slice results and the selected pair.
    logic [BLOCK-1:0] sum0;
    logic [BLOCK-1:0] sum1;
    logic             cout0;
    logic             cout1;
    logic [BLOCK-1:0] slice_sum;
    logic             slice_cout;

    // Partial sum with this slice filled in, and what the register captures.
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_d;

    // Stage registers.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             valid_reg;

    if (gi == 0) begin : gen_src
      // First stage takes operands straight from the input port; B is
      // inverted and carry-in forced to 1 for subtraction.
      assign src_a     = in_a;
      assign src_b     = in_sub ? ~in_b : in_b;
      assign src_cin   = in_sub | in_cin;
      assign src_sum   = '0;
      assign src_valid = accept;
    end else begin : gen_src
      assign src_a     = gen_stage[gi-1].a_reg;
      assign src_b     = gen_stage[gi-1].b_reg;
      assign src_cin   = gen_stage[gi-1].carry_reg;
      assign src_sum   = gen_stage[gi-1].sum_reg;
      assign src_valid = gen_stage[gi-1].valid_reg;
    end

    csel_slice #(
      .BLOCK (BLOCK)
    ) u_slice (
      .a     (src_a[gi*BLOCK +: BLOCK]),
      .b     (src_b[gi*BLOCK +: BLOCK]),
      .sum0  (sum0),
      .cout0 (cout0),
      .sum1  (sum1),
      .cout1 (cout1)
    );

    assign slice_sum  = src_cin ? sum1  : sum0;
    assign slice_cout = src_cin ? cout1 : cout0;

    // Insert this slice's resolved bits into the running sum.
    always_comb begin
      sum_next = src_sum;
      sum_next[gi*BLOCK +: BLOCK] = slice_sum;
    end

    if (gi == S - 1) begin : gen_out
      logic msb_cin;
      logic ovf_next;
      logic ovf_reg;
      logic unused_ops;

      // Carry into the MSB is recovered from the MSB's own sum bit.
      assign msb_cin  = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ slice_sum[BLOCK-1];
      assign ovf_next = msb_cin ^ slice_cout;

`ifdef CSEL_ADD_SAT_EN
      localparam logic [CSEL_MAX_WIDTH-1:0] SAT_MAX_FULL = csel_sat_max(WIDTH);
      localparam logic [CSEL_MAX_WIDTH-1:0] SAT_MIN_FULL = csel_sat_min(WIDTH);
      localparam logic [WIDTH-1:0] SAT_MAX = SAT_MAX_FULL[WIDTH-1:0];
      localparam logic [WIDTH-1:0] SAT_MIN = SAT_MIN_FULL[WIDTH-1:0];

      // Raw MSB set on overflow means two positives wrapped negative.
      assign sum_d = ovf_next ? (sum_next[WIDTH-1] ? SAT_MAX : SAT_MIN) : sum_next;
`else
      assign sum_d = sum_next;
`endif

      // Overflow flag travels with the final result.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= ovf_next;
        end
      end

      // The last stage has no further slices to feed.
      assign unused_ops = ^{a_reg, b_reg};

      assign out_valid = valid_reg;
      assign out_sum   = sum_reg;
      assign out_cout  = carry_reg;
      assign out_ovf   = ovf_reg;
    end else begin : gen_mid
      assign sum_d = sum_next;
    end

    // Stage register: shifts on every advance, bubbles included.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        sum_reg   <= '0;
        carry_reg <= 1'b0;
        a_reg     <= '0;
        b_reg     <= '0;
      end else if (adv) begin
        valid_reg <= src_valid;
        sum_reg   <= sum_d;
        carry_reg <= slice_cout;
        a_reg     <= src_a;
        b_reg     <= src_b;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder (WIDTH=16, BLOCK=4).
// A plain-arithmetic model predicts each accepted beat; a negedge monitor
// compares every consumed result in order and checks stall stability.
module tb_pipelined_csel_adder;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int S     = WIDTH / BLOCK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  always #5 clk = ~clk;

  pipelined_csel_adder #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [WIDTH+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from ordinary integer arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] s;
    logic             cy;
    logic             ov;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    s    = full[WIDTH-1:0];
    cy   = full[WIDTH];
    // Signed overflow: same-sign operands giving a different-sign result.
    ov   = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`ifdef CSEL_ADD_SAT_EN
    if (ov) s = s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    return {ov, cy, s};
  endfunction

  // Monitor: prediction on acceptance, in-order comparison on consumption.
  logic             held_v = 1'b0;
  logic [WIDTH+1:0] held   = '0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (held_v) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_ovf, out_cout, out_sum}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_valid, 0);
        end else begin
          check("result", {out_ovf, out_cout, out_sum}, exp_q.pop_front());
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_ovf, out_cout, out_sum};
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
    end
  end

  // Present one beat and hold it until accepted; returns cycles taken.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, output int tries);
    logic acc;
    tries    = 0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) check("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  // Cycles from the accepting edge until out_valid rises (empty pipe).
  task automatic check_latency(input string name);
    int cnt;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(name, cnt, S);
  endtask

  // Pin the model against a hand-computed value, then run it through the DUT.
  task automatic pin_send(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input logic [WIDTH+1:0] exp);
    int tr;
    check({"pin_", name}, model(a, b, cin, sub), exp);
    wait_drain();
    send(a, b, cin, sub, tr);
    check_latency({"lat_", name});
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    logic [WIDTH-1:0] corner [4];
    corner[0] = 16'h0000;
    corner[1] = 16'hFFFF;
    corner[2] = 16'h7FFF;
    corner[3] = 16'h8000;
    if ($urandom_range(0, 4) == 0) return corner[$urandom_range(0, 3)];
    return WIDTH'($urandom);
  endfunction

  logic rand_done = 1'b0;

  initial begin
    int tr;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;

    // Directed arithmetic cases.
    pin_send("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
`ifdef CSEL_ADD_SAT_EN
    pin_send("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h7FFF});
    pin_send("8000_m1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h8000});
`else
    pin_send("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    pin_send("8000_m1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
`endif
    pin_send("5_m7_c0", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    pin_send("5_m7_c1", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    pin_send("7_m5", 16'h0007, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0002});
    pin_send("0fff_c1", 16'h0FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1000});
    pin_send("f0f0_c1", 16'hF0F0, 16'h0F0F, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
    pin_send("i_plus_i", 16'h0006, 16'h0006, 1'b0, 1'b0, {1'b0, 1'b0, 16'h000C});

    // Backpressure: 8 back-to-back beats, consumer stalls 5 cycles.
    wait_drain();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, tr);
      end
      begin
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        check("bp_first_result", out_valid, 1);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_drop", in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-stream: three beats in flight are discarded.
    for (int i = 0; i < 3; i++) send(16'h1000 + WIDTH'(i), 16'h0100, 1'b0, 1'b0, tr);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_sum", out_sum, 0);
    check("mrst_out_cout", out_cout, 0);
    check("mrst_out_ovf", out_ovf, 0);
    send(16'h1234, 16'h1111, 1'b0, 1'b0, tr);
    check("mrst_first_accept", tr, 1);
    check_latency("mrst_latency");
    wait_drain();

    // Randomised traffic with random input gaps and output backpressure.
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk);
              #1;
            end
          end
          send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tr);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
